// File: rtl/mem_arbiter_if.sv
// Cache-side request/return bundle for the memory arbiter.
// The cache controller is the master; the arbiter is the slave.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IDX_W  = 3
);
    logic              req;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic [IDX_W-1:0]  word_idx;
    logic              done;

    modport master (
        output req, write, addr, wdata,
        input  data, data_valid, word_idx, done
    );

    modport slave (
        input  req, write, addr, wdata,
        output data, data_valid, word_idx, done
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one multi-cycle memory between the I-cache and D-cache
// miss handlers: block-fill read bursts and single-word write-through stores.
module mem_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned BLOCK_WORDS = 8,
    parameter int unsigned MEM_LAT     = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_arbiter_if.slave      icache_if,
    mem_arbiter_if.slave      dcache_if,
    output logic              mem_en_o,
    output logic              mem_wr_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rdata_valid_i
);
    localparam int unsigned IDX_W = $clog2(BLOCK_WORDS);
    localparam int unsigned CNT_W = IDX_W + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2 * BLOCK_WORDS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [CNT_W-1:0]  BURST_LEN  = CNT_W'(BLOCK_WORDS);

    typedef enum logic [1:0] {IDLE, IFILL, DFILL, DWRITE} state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  issue_cnt_q;
    logic [IDX_W-1:0]  ret_cnt_q;
    logic              last_grant_d_q;
    logic              mem_en_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic pick_i_d;
    logic pick_d_d;
    logic i_ret;
    logic d_ret;
    logic last_ret;
    logic unused_ok;

    // On a tie the side that was not served last wins; after reset that is D.
    assign pick_i_d = icache_if.req && (!dcache_if.req || last_grant_d_q);
    assign pick_d_d = dcache_if.req && !pick_i_d;

    // MEM_LAT belongs to the memory; the arbiter just follows mem_rdata_valid.
    assign unused_ok = ^{icache_if.write, icache_if.wdata, (MEM_LAT != 0)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            issue_cnt_q    <= '0;
            ret_cnt_q      <= '0;
            last_grant_d_q <= 1'b0;
            mem_en_q       <= 1'b0;
            mem_wr_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_i_d) begin
                        state_q        <= IFILL;
                        last_grant_d_q <= 1'b0;
                        mem_en_q       <= 1'b1;
                        mem_wr_q       <= 1'b0;
                        mem_addr_q     <= icache_if.addr & ALIGN_MASK;
                        mem_wdata_q    <= '0;
                        issue_cnt_q    <= CNT_W'(1);
                        ret_cnt_q      <= '0;
                    end else if (pick_d_d) begin
                        last_grant_d_q <= 1'b1;
                        mem_en_q       <= 1'b1;
                        ret_cnt_q      <= '0;
                        if (dcache_if.write) begin
                            state_q     <= DWRITE;
                            mem_wr_q    <= 1'b1;
                            mem_addr_q  <= dcache_if.addr;
                            mem_wdata_q <= dcache_if.wdata;
                            issue_cnt_q <= '0;
                        end else begin
                            state_q     <= DFILL;
                            mem_wr_q    <= 1'b0;
                            mem_addr_q  <= dcache_if.addr & ALIGN_MASK;
                            mem_wdata_q <= '0;
                            issue_cnt_q <= CNT_W'(1);
                        end
                    end
                end
                IFILL, DFILL: begin
                    // issue_cnt_q counts reads already presented, including this cycle's.
                    if (issue_cnt_q < BURST_LEN) begin
                        issue_cnt_q <= issue_cnt_q + CNT_W'(1);
                        mem_addr_q  <= mem_addr_q + ADDR_W'(2);
                    end else begin
                        mem_en_q   <= 1'b0;
                        mem_addr_q <= '0;
                    end
                    if (mem_rdata_valid_i) begin
                        if (ret_cnt_q == LAST_IDX) begin
                            state_q     <= IDLE;
                            ret_cnt_q   <= '0;
                            issue_cnt_q <= '0;
                            mem_en_q    <= 1'b0;
                            mem_addr_q  <= '0;
                        end else begin
                            ret_cnt_q <= ret_cnt_q + IDX_W'(1);
                        end
                    end
                end
                DWRITE: begin
                    state_q     <= IDLE;
                    mem_en_q    <= 1'b0;
                    mem_wr_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_ret    = mem_rdata_valid_i && (state_q == IFILL);
    assign d_ret    = mem_rdata_valid_i && (state_q == DFILL);
    assign last_ret = (ret_cnt_q == LAST_IDX);

    assign icache_if.data_valid = i_ret;
    assign icache_if.data       = i_ret ? mem_rdata_i : '0;
    assign icache_if.word_idx   = i_ret ? ret_cnt_q : '0;
    assign icache_if.done       = i_ret && last_ret;

    assign dcache_if.data_valid = d_ret;
    assign dcache_if.data       = d_ret ? mem_rdata_i : '0;
    assign dcache_if.word_idx   = d_ret ? ret_cnt_q : '0;
    assign dcache_if.done       = (d_ret && last_ret) || (state_q == DWRITE);

    assign mem_en_o    = mem_en_q;
    assign mem_wr_o    = mem_wr_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
endmodule
